// File: rtl/move_controller.sv
// Move-entry and board-commit FSM: captures source/target squares, waits on the path checker, commits the move.
// Latency: verdict sampled CHECK_LATENCY edges after target select; board/turn/move_done update one edge later.
// Backpressure: none; select pulses arriving in CHECK or COMMIT are dropped. Optional feature macro: MOVE_CTRL_PROMOTE_EN.
module move_controller #(
    parameter int unsigned CHECK_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         select,
    input  logic [5:0]   cursor,
    input  logic         allow_path,
    output logic [255:0] board_out,
    output logic [5:0]   from_sq,
    output logic [5:0]   to_sq,
    output logic         check_req,
    output logic         src_valid,
    output logic         turn,
    output logic         move_done,
    output logic         move_reject
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SRC_HELD = 2'd1,
        CHECK    = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    // Counter value at which the checker verdict is sampled.
    localparam logic [3:0] CNT_LAST = 4'(CHECK_LATENCY - 1);

    // Back-rank piece kind for file f (rook, knight, bishop, queen, king, bishop, knight, rook).
    function automatic logic [2:0] back_rank(input int f);
        logic [2:0] k;
        case (f)
            0, 7:    k = 3'd5;
            1, 6:    k = 3'd4;
            2, 5:    k = 3'd3;
            3:       k = 3'd2;
            default: k = 3'd1;
        endcase
        return k;
    endfunction

    // Standard chess starting position, 4 bits per square, a1 in the low nibble.
    function automatic logic [255:0] start_board();
        logic [255:0] b;
        b = '0;
        for (int f = 0; f < 8; f++) begin
            b[f*4 +: 4]        = {1'b0, back_rank(f)};
            b[(8 + f)*4 +: 4]  = 4'd6;
            b[(48 + f)*4 +: 4] = 4'd14;
            b[(56 + f)*4 +: 4] = {1'b1, back_rank(f)};
        end
        return b;
    endfunction

    localparam logic [255:0] RESET_BOARD = start_board();

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [255:0]   board_q, board_d;
    logic [5:0]     from_q, from_d;
    logic [5:0]     to_q, to_d;
    logic           turn_q, turn_d;
    logic           check_req_q, check_req_d;
    logic           src_valid_q, src_valid_d;
    logic           move_done_q, move_done_d;
    logic           move_reject_q, move_reject_d;

    logic [3:0]     cursor_piece;
    logic           cursor_own;
    logic [3:0]     moving_piece;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        board_d       = board_q;
        from_d        = from_q;
        to_d          = to_q;
        turn_d        = turn_q;
        move_done_d   = 1'b0;
        move_reject_d = 1'b0;

        cursor_piece = board_q[{cursor, 2'b00} +: 4];
        cursor_own   = (cursor_piece[2:0] != 3'd0) && (cursor_piece[3] == turn_q);
        moving_piece = board_q[{from_q, 2'b00} +: 4];

`ifdef MOVE_CTRL_PROMOTE_EN
        // Pawns reaching the far rank become queens of the same colour.
        if (moving_piece == 4'd6 && to_q[5:3] == 3'd7) begin
            moving_piece = 4'd2;
        end else if (moving_piece == 4'd14 && to_q[5:3] == 3'd0) begin
            moving_piece = 4'd10;
        end
`endif

        case (state_q)
            IDLE: begin
                if (select && cursor_own) begin
                    from_d  = cursor;
                    state_d = SRC_HELD;
                end
            end
            SRC_HELD: begin
                if (select) begin
                    if (cursor == from_q) begin
                        state_d = IDLE;
                    end else if (cursor_own) begin
                        from_d = cursor;
                    end else begin
                        to_d    = cursor;
                        cnt_d   = 4'd0;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    if (allow_path) begin
                        state_d = COMMIT;
                    end else begin
                        move_reject_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            default: begin
                // COMMIT: source cleared first; target write wins (they never coincide).
                board_d[{from_q, 2'b00} +: 4] = 4'd0;
                board_d[{to_q, 2'b00} +: 4]   = moving_piece;
                turn_d      = ~turn_q;
                move_done_d = 1'b1;
                state_d     = IDLE;
            end
        endcase

        check_req_d = (state_d == CHECK);
        src_valid_d = (state_d == SRC_HELD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            board_q       <= RESET_BOARD;
            from_q        <= 6'd0;
            to_q          <= 6'd0;
            turn_q        <= 1'b0;
            check_req_q   <= 1'b0;
            src_valid_q   <= 1'b0;
            move_done_q   <= 1'b0;
            move_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            board_q       <= board_d;
            from_q        <= from_d;
            to_q          <= to_d;
            turn_q        <= turn_d;
            check_req_q   <= check_req_d;
            src_valid_q   <= src_valid_d;
            move_done_q   <= move_done_d;
            move_reject_q <= move_reject_d;
        end
    end

    assign board_out   = board_q;
    assign from_sq     = from_q;
    assign to_sq       = to_q;
    assign check_req   = check_req_q;
    assign src_valid   = src_valid_q;
    assign turn        = turn_q;
    assign move_done   = move_done_q;
    assign move_reject = move_reject_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with CHECK_LATENCY = 4.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
// Expected board is kept in a bench-side model updated per committed move.
module tb_move_controller;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         select = 1'b0;
    logic [5:0]   cursor = 6'd0;
    logic         allow_path = 1'b0;
    logic [255:0] board_out;
    logic [5:0]   from_sq;
    logic [5:0]   to_sq;
    logic         check_req;
    logic         src_valid;
    logic         turn;
    logic         move_done;
    logic         move_reject;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] exp_board;
    logic         exp_turn;

    move_controller #(.CHECK_LATENCY(L)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .select(select),
        .cursor(cursor),
        .allow_path(allow_path),
        .board_out(board_out),
        .from_sq(from_sq),
        .to_sq(to_sq),
        .check_req(check_req),
        .src_valid(src_valid),
        .turn(turn),
        .move_done(move_done),
        .move_reject(move_reject)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] ref_start();
        logic [255:0] b;
        logic [3:0] back [8];
        back = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd3, 4'd4, 4'd5};
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[i*4 +: 4]        = back[i];
            b[(8 + i)*4 +: 4]  = 4'd6;
            b[(48 + i)*4 +: 4] = 4'd14;
            b[(56 + i)*4 +: 4] = back[i] | 4'd8;
        end
        return b;
    endfunction

    function automatic logic [3:0] sq_of(input logic [255:0] b, input int i);
        return b[i*4 +: 4];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [5:0] sq);
        cursor = sq;
        select = 1'b1;
        tick();
        select = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full move: source select, target select, verdict, then commit or reject checks.
    task automatic do_move(input logic [5:0] f, input logic [5:0] t, input logic allow, input logic [3:0] landed);
        allow_path = allow;
        pulse(f);
        pulse(t);
        chk("mv_check_req_on", check_req, 1'b1);
        repeat (L) tick();
        chk("mv_check_req_off", check_req, 1'b0);
        if (!allow) begin
            chk("mv_reject_pulse", move_reject, 1'b1);
            chk("mv_reject_board", board_out, exp_board);
            tick();
            chk("mv_reject_single", move_reject, 1'b0);
            chk("mv_reject_turn", turn, exp_turn);
        end else begin
            chk("mv_board_stable", board_out, exp_board);
            tick();
            exp_board[f*4 +: 4] = 4'd0;
            exp_board[t*4 +: 4] = landed;
            exp_turn = ~exp_turn;
            chk("mv_done_pulse", move_done, 1'b1);
            chk("mv_board", board_out, exp_board);
            chk("mv_turn", turn, exp_turn);
            tick();
            chk("mv_done_single", move_done, 1'b0);
        end
    endtask

    initial begin
        exp_board = ref_start();
        exp_turn  = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_board", board_out, exp_board);
        chk("rst_turn", turn, 1'b0);
        chk("rst_from", from_sq, 6'd0);
        chk("rst_to", to_sq, 6'd0);
        chk("rst_check_req", check_req, 1'b0);
        chk("rst_src_valid", src_valid, 1'b0);
        chk("rst_done", move_done, 1'b0);
        chk("rst_reject", move_reject, 1'b0);
        rst_n = 1'b1;
        tick();

        // Enemy piece on white's turn is ignored.
        pulse(6'd52);
        chk("enemy_src_valid", src_valid, 1'b0);
        chk("enemy_check_req", check_req, 1'b0);
        tick();
        chk("enemy_no_pulse", {move_done, move_reject}, 2'b00);

        // Select, deselect, select, reselect, target.
        pulse(6'd1);
        chk("sel1_src_valid", src_valid, 1'b1);
        chk("sel1_from", from_sq, 6'd1);
        pulse(6'd1);
        chk("desel_src_valid", src_valid, 1'b0);
        pulse(6'd1);
        pulse(6'd6);
        chk("resel_from", from_sq, 6'd6);
        chk("resel_src_valid", src_valid, 1'b1);
        allow_path = 1'b0;
        pulse(6'd21);
        chk("tgt_from", from_sq, 6'd6);
        chk("tgt_to", to_sq, 6'd21);
        chk("tgt_check_req", check_req, 1'b1);
        chk("tgt_src_valid", src_valid, 1'b0);
        repeat (L - 1) tick();
        chk("tgt_check_req_last", check_req, 1'b1);
        chk("tgt_no_reject_yet", move_reject, 1'b0);
        tick();
        chk("tgt_reject", move_reject, 1'b1);
        chk("tgt_check_req_off", check_req, 1'b0);
        tick();
        chk("tgt_reject_single", move_reject, 1'b0);
        chk("tgt_board", board_out, exp_board);

        // Queen d1 to d8 refused by the checker.
        do_move(6'd3, 6'd59, 1'b0, 4'd0);

        // e2-e4 accepted, with a select pulse during CHECK that must be dropped.
        allow_path = 1'b1;
        pulse(6'd12);
        pulse(6'd28);
        pulse(6'd13);
        repeat (L - 1) tick();
        chk("e4_check_req_off", check_req, 1'b0);
        chk("e4_board_hold", board_out, exp_board);
        chk("e4_no_done_yet", move_done, 1'b0);
        tick();
        chk("e4_done", move_done, 1'b1);
        chk("e4_sq28", sq_of(board_out, 28), 4'd6);
        chk("e4_sq12", sq_of(board_out, 12), 4'd0);
        chk("e4_turn", turn, 1'b1);
        tick();
        chk("e4_done_single", move_done, 1'b0);
        chk("e4_drop_src_valid", src_valid, 1'b0);
        exp_board[12*4 +: 4] = 4'd0;
        exp_board[28*4 +: 4] = 4'd6;
        exp_turn = 1'b1;
        chk("e4_board_full", board_out, exp_board);

        // Reset in the middle of CHECK discards the move.
        pulse(6'd51);
        pulse(6'd43);
        tick();
        chk("midrst_in_check", check_req, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_board = ref_start();
        exp_turn  = 1'b0;
        chk("midrst_board", board_out, exp_board);
        chk("midrst_turn", turn, 1'b0);
        chk("midrst_check_req", check_req, 1'b0);
        chk("midrst_done", move_done, 1'b0);
        repeat (L + 2) tick();
        chk("midrst_still_no_done", move_done, 1'b0);
        chk("midrst_board_after", board_out, exp_board);

        // Pawn to the last rank: g2xg7, black Ng8-f6, g7-g8.
        do_move(6'd14, 6'd54, 1'b1, 4'd6);
        do_move(6'd62, 6'd45, 1'b1, 4'd12);
`ifdef MOVE_CTRL_PROMOTE_EN
        do_move(6'd54, 6'd62, 1'b1, 4'd2);
        chk("promo_sq62", sq_of(board_out, 62), 4'd2);
`else
        do_move(6'd54, 6'd62, 1'b1, 4'd6);
        chk("promo_sq62", sq_of(board_out, 62), 4'd6);
`endif
        chk("promo_sq54", sq_of(board_out, 54), 4'd0);
        chk("promo_turn", turn, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/move_controller.md
# move_controller

Sequential move-entry and board-commit controller for the chess game logic. Captures a source and a target square from cursor/select inputs and presents the pair to the path checker. It samples the checker's verdict and, on acceptance, rewrites the 256-bit board register and hands the turn to the other side. It sits directly upstream of the path checker, which consumes `from_sq`/`to_sq`/`board_out`, and it also consumes the path checker's `allow_path` result.

## Interface
- `CHECK_LATENCY`, default 1: cycles `check_req` is held before `allow_path` is sampled; legal range 1–15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `select`  in  1  one-cycle select pulse from the input debouncer.
- `cursor`  in  6  square index under the cursor: rank = `[5:3]`, file = `[2:0]`, a1 = 0, h8 = 63.
- `allow_path`  in  1  path-checker verdict for the current `from_sq`/`to_sq`/`board_out`.
- `board_out`  out  256  board state; square i occupies bits `[4i+3:4i]`.
- `from_sq`  out  6  latched source square.
- `to_sq`  out  6  latched target square.
- `check_req`  out  1  high while the FSM waits on the checker.
- `src_valid`  out  1  high in state SRC_HELD, for source highlighting.
- `turn`  out  1  side to move: 0 = white, 1 = black.
- `move_done`  out  1  one-cycle pulse, move committed.
- `move_reject`  out  1  one-cycle pulse, checker refused the move.

## Operation
- Piece code: bit 3 = colour (0 = white, 1 = black); bits `[2:0]`: 0 empty, 1 king, 2 queen, 3 bishop, 4 knight, 5 rook, 6 pawn. A square is empty iff bits `[2:0]` = 0.
- Reset values:
  - `board_out` = standard start position.
    - Squares 0–7 = 5,4,3,2,1,3,4,5.
    - Squares 8–15 = 6.
    - Squares 48–55 = 14.
    - Squares 56–63 = 13,12,11,10,9,11,12,13.
    - All other squares = 0.
  - `turn` = 0.
  - `from_sq` = `to_sq` = 0.
  - `check_req`, `src_valid`, `move_done`, `move_reject` = 0.
  - State = IDLE, wait counter = 0.
- "Own piece" means non-empty with colour equal to `turn`.
- FSM states: IDLE, SRC_HELD, CHECK, COMMIT.
  - IDLE: on `select` with an own piece at `cursor`: `from_sq` ← `cursor`, go to SRC_HELD. Any other `select` is ignored.
  - SRC_HELD: on `select`:
    - `cursor` == `from_sq` → IDLE (deselect).
    - Other own piece at `cursor` → `from_sq` ← `cursor`, stay (reselect).
    - Otherwise → `to_sq` ← `cursor`, counter ← 0, go to CHECK.
  - CHECK: `check_req` = 1; counter increments each cycle.
    - When counter == `CHECK_LATENCY`−1, sample `allow_path` at that edge.
    - 1 → COMMIT.
    - 0 → `move_reject` pulses, go to IDLE.
  - COMMIT: at the edge leaving COMMIT:
    - square `to_sq` ← piece at `from_sq`;
    - square `from_sq` ← 0;
    - `turn` inverts;
    - `move_done` pulses;
    - go to IDLE.
- `select` is ignored in CHECK and COMMIT; no queuing.
- Capturing any enemy piece, including the king, is a plain overwrite. Game-end detection is out of scope.
- `from_sq`/`to_sq` hold their last values in IDLE.
- `rst_n` low in any state, mid-move included, restores every reset value at that edge. Any pending move is discarded.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Target `select` accepted at edge E0:
  - `check_req` is high from E0 through E(`CHECK_LATENCY`).
  - `allow_path` must be valid and stable in the cycle before edge E(`CHECK_LATENCY`).
  - New `board_out`, new `turn` and `move_done` = 1 all appear together after E(`CHECK_LATENCY`+1).
- Reject: `move_reject` = 1 for the single cycle after E(`CHECK_LATENCY`); `board_out` and `turn` unchanged.
- `board_out` is stable whenever `check_req` = 1; the checker may read it freely.
- Minimum select-to-select spacing for back-to-back moves: `CHECK_LATENCY`+2 cycles. Earlier pulses are dropped.

## Configuration
- `MOVE_CTRL_PROMOTE_EN` defined: in COMMIT, a white pawn (6) landing on rank 7 is written as a white queen (2), and a black pawn (14) landing on rank 0 is written as a black queen (10).
- Macro undefined: pawns are copied unchanged; no promotion logic is synthesised.

## Test plan
- Reset, then select 12 and select 28 with `allow_path` = 1 → after `CHECK_LATENCY`+1 edges: square 28 = 6, square 12 = 0, `turn` = 1, `move_done` pulses once.
- From reset, select 52 (black pawn on white's turn) → state stays IDLE, `src_valid` = 0, no pulses.
- Select 1, select 1 again → `src_valid` drops, IDLE. Then select 1, select 6, select 21 → `from_sq` = 6, `to_sq` = 21, `check_req` = 1.
- Select 3, select 59 with `allow_path` = 0 → `move_reject` is a single-cycle pulse, `board_out` equals the reset board, `turn` = 0.
- Assert `rst_n` = 0 while in CHECK with `CHECK_LATENCY` = 4 → next cycle: reset board, `turn` = 0, `check_req` = 0, no `move_done`.
- With `MOVE_CTRL_PROMOTE_EN`: preload a white pawn on square 54 and empty square 62, select 54 then 62 with `allow_path` = 1 → square 62 = 2. Without the macro → square 62 = 6.
